// File: rtl/ram_4wide_reader.sv
// Read-side controller for the 4-wide register-file RAM: registered lane reads,
// same-edge write forwarding, r0/mask zeroing and an in-order response FIFO.
module ram_4wide_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NPORTS     = 4,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [NPORTS-1:0][ADDR_WIDTH-1:0]    req_addr,
    input  logic [NPORTS-1:0]                    req_mask,
    output logic [NPORTS-1:0][ADDR_WIDTH-1:0]    rd_addr,
    input  logic [NPORTS-1:0][DATA_WIDTH-1:0]    rd_data,
    input  logic [NPORTS-1:0]                    wr_en,
    input  logic [NPORTS-1:0][ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NPORTS-1:0][DATA_WIDTH-1:0]    wr_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [NPORTS-1:0][DATA_WIDTH-1:0]    rsp_data,
    output logic [NPORTS-1:0]                    rsp_mask
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] lane_result(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  hit,
        input logic [DATA_WIDTH-1:0] fwd,
        input logic [DATA_WIDTH-1:0] ram
    );
        if (!en || addr == '0)
            return '0;
        else if (hit)
            return fwd;
        else
            return ram;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic                                 accept;
    logic [NPORTS-1:0]                    fwd_hit_p0;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]    fwd_data_p0;

    logic                                 vld_p1;
    logic [NPORTS-1:0]                    mask_p1;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0]    addr_p1;
    logic [NPORTS-1:0]                    fwd_hit_p1;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]    fwd_data_p1;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]    result_p1;

    logic [NPORTS-1:0][DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic [NPORTS-1:0]                    fifo_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]                     wr_ptr;
    logic [PTR_W-1:0]                     rd_ptr;
    logic [CNT_W-1:0]                     count;
    logic [CNT_W:0]                       occ;
    logic                                 push;
    logic                                 pop;

    // ---- Stage P0: request accept, RAM address, write snapshot ----
    assign rd_addr = req_addr;

    // Credit counts the request already in flight so a push can never overflow.
    assign occ       = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
    assign req_ready = rst_n && (occ < DEPTH_OCC);
    assign accept    = req_valid && req_ready;

    // Ascending port scan: the highest writing port wins, as in the RAM.
    always_comb begin
        fwd_hit_p0  = '0;
        fwd_data_p0 = '0;
        for (int l = 0; l < NPORTS; l++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (wr_en[p] && wr_addr[p] == req_addr[l]) begin
                    fwd_hit_p0[l]  = 1'b1;
                    fwd_data_p0[l] = wr_data[p];
                end
            end
        end
    end

    // ---- Stage P1: RAM data returns, lane correction, FIFO push ----
    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mask_p1     <= req_mask;
            addr_p1     <= req_addr;
            fwd_hit_p1  <= fwd_hit_p0;
            fwd_data_p1 <= fwd_data_p0;
        end
    end

    always_comb begin
        result_p1 = '0;
        for (int l = 0; l < NPORTS; l++)
            result_p1[l] = lane_result(mask_p1[l], addr_p1[l], fwd_hit_p1[l],
                                       fwd_data_p1[l], rd_data[l]);
    end

    // ---- Response FIFO ----
    assign push = vld_p1;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= result_p1;
            fifo_mask[wr_ptr] <= mask_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are forced to zero when empty so reset never exposes stale entries.
    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_mask  = rsp_valid ? fifo_mask[rd_ptr] : '0;

endmodule
